keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
4x4 matrix keypad scanner and debouncer feeding the locker FSM's key_in/key_valid/enter inputs.
- Drives columns one at a time, samples the rows, and debounces a single pressed key.
- Emits exactly one single-cycle pulse per press: digit keys produce key_valid with key_in, and '#' produces enter.
- Sits between the physical keypad pins and the locker; its outputs connect port-for-port to the locker.

Parameters:
SCAN_DIV, 1000, clocks per column step (10 us at 100 MHz); legal range >= 4.
DEBOUNCE_CNT, 4, consecutive identical row samples required for press and for release; legal range >= 1.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low (0 = reset)
row_in  input  4  keypad rows, active-low, asynchronous (pulled up externally)
col_out  output  4  keypad column drive, active-low, one-hot-zero
key_in  output  4  code of last digit key (0-9); held between presses
key_valid  output  1  one-cycle pulse, key_in valid in same cycle
enter  output  1  one-cycle pulse on '#' press

Behaviour:
- Reset (reset==0 at clk edge) forces:
  - col_out=4'b1110, key_in=0, key_valid=0, enter=0.
  - All counters cleared; state=SCAN, column index 0; synchronizer flops set to 4'b1111.
- Reset overrides all other activity. A reset mid-debounce or mid-hold emits no pulse.
- row_in passes through a 2-flop synchronizer. Only the synchronized value is used.
- Sample point: the last clock of each SCAN_DIV-clock column period. This gives at least 2 settle clocks after col_out changes.
- Key map (row r, col c), with row 0 = row_in[0] and col 0 = col_out[0]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Digits 0-9 produce key_valid with key_in = digit. '#' produces enter. '*' and A-D are recognised and debounced but produce no pulse.
- State machine:
  - SCAN: col_out walks 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per period.
    - At the sample point, if exactly one row is low: latch (row, col), set match count=1, go to DEBOUNCE; the column stays frozen.
    - Zero rows low, or more than one row low: advance to the next column.
  - DEBOUNCE: column frozen; evaluate at each sample point.
    - Same single row low: increment count. When count reaches DEBOUNCE_CNT, go to EMIT.
    - Any other pattern (bounce, release, multi-row): go to SCAN, advance to the next column, emit nothing.
    - DEBOUNCE_CNT=1 goes straight from the SCAN detect to EMIT.
  - EMIT: lasts one clock.
    - Digit key: key_valid=1 and key_in updates in this same clock.
    - '#': enter=1; key_in unchanged.
    - key_valid and enter are never both 1. Then go to HOLD.
  - HOLD: column frozen; evaluate at each sample point.
    - All rows high: increment release count.
    - Any row low: clear release count.
    - Release count reaches DEBOUNCE_CNT: go to SCAN, same column, no pulse.
    - No auto-repeat: a held key yields exactly one pulse.
- Simultaneous keys: the first single-row hit in scan order wins. A second key pressed during HOLD is ignored until the first is released and the scan resumes.
- A key held through reset release is detected and emitted normally once scanning resumes.
- Pulse latency from a clean press (rows stable): at most (4 + DEBOUNCE_CNT) column periods + 3 clocks.
- Counters are sized to hold SCAN_DIV-1 and DEBOUNCE_CNT without wrap; the scan counter wraps 0..SCAN_DIV-1.
- Outputs are registered; there is no combinational path from row_in to any output.

Test Plan:
Bench setup for all scenarios:
- SCAN_DIV=4, DEBOUNCE_CNT=3.
- Keypad model: row_in[r] = 0 iff key (r,c) is pressed and col_out[c]==0.
1. Reset pulse (reset=0 for 2 clks) -> col_out=1110, key_in=0, key_valid=0, enter=0. Idle 100 clks -> no pulses, col_out cycles every 4 clks.
2. Press '4' (r1,c0), hold 200 clks, release -> exactly one key_valid cycle with key_in=4. No repeat; key_in stays 4 after release.
3. Sequence 4,2,7,9,'#' (each held 80 clks, 80 clks gap) -> key_valid pulses with key_in 4,2,7,9 in order, then one enter pulse with key_in still 9. Compare against locker: open=1 one cycle after enter.
4. Bounce: press '5' for 1 sample period, release 1 period, repeat 3x, then release -> zero pulses. Then press '5' cleanly -> one pulse, key_in=5.
5. Multi-key: '1' and '4' held together (same column) -> no pulse. '1' and '2' pressed together -> one pulse for the key found first in scan order. Second key released while first held -> no extra pulse.
6. Reset mid-debounce: press '8', assert reset after 2 samples, hold reset 3 clks, release key before reset deasserts -> no key_valid, key_in=0. Press '*' and 'A' -> no pulses.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with press/release
// debouncing. Emits one key_valid pulse per digit press and one enter
// pulse per '#' press; '*' and A-D are debounced but produce no pulse.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_in,
  output logic       key_valid,
  output logic       enter
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_CNT);
  localparam logic [DEB_W-1:0]  DEB_ONE    = DEB_W'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    HOLD     = 2'd3
  } stateT;

  stateT             r_state;
  stateT             w_nextState;
  logic [3:0]        r_rowMeta;
  logic [3:0]        r_rowSync;
  logic [SCAN_W-1:0] r_scanCnt;
  logic [1:0]        r_colIdx;
  logic [1:0]        w_nextColIdx;
  logic [3:0]        r_colOut;
  logic [1:0]        r_keyRow;
  logic [1:0]        w_nextKeyRow;
  logic [1:0]        r_keyCol;
  logic [1:0]        w_nextKeyCol;
  logic [DEB_W-1:0]  r_matchCnt;
  logic [DEB_W-1:0]  w_nextMatchCnt;
  logic [DEB_W-1:0]  r_relCnt;
  logic [DEB_W-1:0]  w_nextRelCnt;
  logic [3:0]        r_keyIn;
  logic [3:0]        w_nextKeyIn;
  logic              r_keyValid;
  logic              w_nextKeyValid;
  logic              r_enter;
  logic              w_nextEnter;

  logic              w_sample;
  logic [3:0]        w_rowLow;
  logic              w_oneLow;
  logic [1:0]        w_lowIdx;
  logic [5:0]        w_decoded;

  // Maps (row, col) to {isDigit, isEnter, code}; code is the digit value.
  function automatic logic [5:0] decodeKey(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] res;
    res = 6'b00_0000;
    case ({row, col})
      4'b00_00: res = {2'b10, 4'd1};
      4'b00_01: res = {2'b10, 4'd2};
      4'b00_10: res = {2'b10, 4'd3};
      4'b01_00: res = {2'b10, 4'd4};
      4'b01_01: res = {2'b10, 4'd5};
      4'b01_10: res = {2'b10, 4'd6};
      4'b10_00: res = {2'b10, 4'd7};
      4'b10_01: res = {2'b10, 4'd8};
      4'b10_10: res = {2'b10, 4'd9};
      4'b11_01: res = {2'b10, 4'd0};
      4'b11_10: res = {2'b01, 4'd0};
      default:  res = 6'b00_0000;
    endcase
    return res;
  endfunction

  assign w_sample  = (r_scanCnt == SCAN_LAST);
  assign w_rowLow  = ~r_rowSync;
  assign w_decoded = decodeKey(w_nextKeyRow, w_nextKeyCol);

  // Classify the synchronized row pattern: exactly one row low, and which.
  always_comb begin
    w_oneLow = 1'b0;
    w_lowIdx = 2'd0;
    case (w_rowLow)
      4'b0001: begin w_oneLow = 1'b1; w_lowIdx = 2'd0; end
      4'b0010: begin w_oneLow = 1'b1; w_lowIdx = 2'd1; end
      4'b0100: begin w_oneLow = 1'b1; w_lowIdx = 2'd2; end
      4'b1000: begin w_oneLow = 1'b1; w_lowIdx = 2'd3; end
      default: begin w_oneLow = 1'b0; w_lowIdx = 2'd0; end
    endcase
  end

  // Two-flop synchronizer; idle rows read high so reset value is all ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rowMeta <= 4'b1111;
      r_rowSync <= 4'b1111;
    end else begin
      r_rowMeta <= row_in;
      r_rowSync <= r_rowMeta;
    end
  end

  // Free-running column period counter; its last count is the sample point.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_scanCnt <= '0;
    end else if (r_scanCnt == SCAN_LAST) begin
      r_scanCnt <= '0;
    end else begin
      r_scanCnt <= r_scanCnt + SCAN_W'(1);
    end
  end

  // Next-state and pulse decision; a pulse is registered on entry to EMIT
  // so that key_valid/enter are high exactly while the state is EMIT.
  always_comb begin
    w_nextState    = r_state;
    w_nextColIdx   = r_colIdx;
    w_nextKeyRow   = r_keyRow;
    w_nextKeyCol   = r_keyCol;
    w_nextMatchCnt = r_matchCnt;
    w_nextRelCnt   = r_relCnt;
    w_nextKeyIn    = r_keyIn;
    w_nextKeyValid = 1'b0;
    w_nextEnter    = 1'b0;

    case (r_state)
      SCAN: begin
        if (w_sample) begin
          if (w_oneLow) begin
            w_nextKeyRow   = w_lowIdx;
            w_nextKeyCol   = r_colIdx;
            w_nextMatchCnt = DEB_ONE;
            if (DEB_TARGET == DEB_ONE) begin
              w_nextState = EMIT;
            end else begin
              w_nextState = DEBOUNCE;
            end
          end else begin
            w_nextColIdx = r_colIdx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (w_sample) begin
          if (w_oneLow && (w_lowIdx == r_keyRow)) begin
            w_nextMatchCnt = r_matchCnt + DEB_ONE;
            if ((r_matchCnt + DEB_ONE) == DEB_TARGET) begin
              w_nextState = EMIT;
            end
          end else begin
            w_nextState    = SCAN;
            w_nextColIdx   = r_colIdx + 2'd1;
            w_nextMatchCnt = '0;
          end
        end
      end
      EMIT: begin
        w_nextState    = HOLD;
        w_nextMatchCnt = '0;
        w_nextRelCnt   = '0;
      end
      HOLD: begin
        if (w_sample) begin
          if (r_rowSync == 4'b1111) begin
            if ((r_relCnt + DEB_ONE) == DEB_TARGET) begin
              w_nextState  = SCAN;
              w_nextRelCnt = '0;
            end else begin
              w_nextRelCnt = r_relCnt + DEB_ONE;
            end
          end else begin
            w_nextRelCnt = '0;
          end
        end
      end
      default: begin
        w_nextState = SCAN;
      end
    endcase

    if (w_nextState == EMIT) begin
      if (w_decoded[5]) begin
        w_nextKeyValid = 1'b1;
        w_nextKeyIn    = w_decoded[3:0];
      end else if (w_decoded[4]) begin
        w_nextEnter = 1'b1;
      end
    end
  end

  // State, column drive, latched key and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= SCAN;
      r_colIdx   <= 2'd0;
      r_colOut   <= 4'b1110;
      r_keyRow   <= 2'd0;
      r_keyCol   <= 2'd0;
      r_matchCnt <= '0;
      r_relCnt   <= '0;
      r_keyIn    <= 4'd0;
      r_keyValid <= 1'b0;
      r_enter    <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_colIdx   <= w_nextColIdx;
      r_colOut   <= ~(4'b0001 << w_nextColIdx);
      r_keyRow   <= w_nextKeyRow;
      r_keyCol   <= w_nextKeyCol;
      r_matchCnt <= w_nextMatchCnt;
      r_relCnt   <= w_nextRelCnt;
      r_keyIn    <= w_nextKeyIn;
      r_keyValid <= w_nextKeyValid;
      r_enter    <= w_nextEnter;
    end
  end

  assign col_out   = r_colOut;
  assign key_in    = r_keyIn;
  assign key_valid = r_keyValid;
  assign enter     = r_enter;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural
// keypad matrix (row low iff a pressed key's column is driven low).
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_in;
  logic        key_valid;
  logic        enter;

  logic [15:0] pressed;
  int          checks;
  int          failures;
  int          validCount;
  int          enterCount;
  int          bothCount;
  logic [3:0]  enterKeyIn;
  logic [3:0]  keyLog [0:63];

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_in    (key_in),
    .key_valid (key_valid),
    .enter     (enter)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: key index is row*4+col.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Pulse monitor on the falling edge, counting high cycles of each pulse.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      keyLog[validCount % 64] = key_in;
      validCount++;
    end
    if (enter === 1'b1) begin
      enterKeyIn = key_in;
      enterCount++;
    end
    if ((key_valid === 1'b1) && (enter === 1'b1)) bothCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input int holdClks, input int gapClks);
    pressed[idx] = 1'b1;
    repeat (holdClks) @(posedge clk);
    pressed[idx] = 1'b0;
    repeat (gapClks) @(posedge clk);
    #1;
  endtask

  task automatic waitCol(input logic [3:0] want);
    logic       found;
    logic [3:0] prev;
    found = 1'b0;
    prev  = col_out;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if ((col_out == want) && (prev != want)) found = 1'b1;
      prev = col_out;
    end
    checkOutput("waitCol", {31'd0, found}, 32'd1);
  endtask

  // Directed test sequence.
  initial begin
    int         baseV;
    int         baseE;
    logic [3:0] c1;
    checks     = 0;
    failures   = 0;
    validCount = 0;
    enterCount = 0;
    bothCount  = 0;
    enterKeyIn = 4'd0;
    pressed    = 16'd0;
    reset      = 1'b0;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_col", {28'd0, col_out}, 32'he);
    checkOutput("rst_key", {28'd0, key_in}, 32'd0);
    checkOutput("rst_valid", {31'd0, key_valid}, 32'd0);
    checkOutput("rst_enter", {31'd0, enter}, 32'd0);
    reset = 1'b1;

    $display("[TB] idle scan");
    baseV = validCount;
    baseE = enterCount;
    for (int i = 0; i < 4; i++) begin
      c1 = col_out;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("col_walk", {28'd0, col_out}, {28'd0, c1[2:0], c1[3]});
    end
    repeat (84) @(posedge clk);
    #1;
    checkOutput("idle_valid", validCount - baseV, 32'd0);
    checkOutput("idle_enter", enterCount - baseE, 32'd0);

    $display("[TB] single press 4");
    baseV = validCount;
    applyStimulus(4, 200, 40);
    checkOutput("p4_count", validCount - baseV, 32'd1);
    checkOutput("p4_log", {28'd0, keyLog[baseV % 64]}, 32'd4);
    checkOutput("p4_keyin", {28'd0, key_in}, 32'd4);

    $display("[TB] sequence 4 2 7 9 #");
    baseV = validCount;
    baseE = enterCount;
    applyStimulus(4, 80, 80);
    applyStimulus(1, 80, 80);
    applyStimulus(8, 80, 80);
    applyStimulus(10, 80, 80);
    applyStimulus(14, 80, 80);
    checkOutput("seq_count", validCount - baseV, 32'd4);
    checkOutput("seq_k0", {28'd0, keyLog[(baseV + 0) % 64]}, 32'd4);
    checkOutput("seq_k1", {28'd0, keyLog[(baseV + 1) % 64]}, 32'd2);
    checkOutput("seq_k2", {28'd0, keyLog[(baseV + 2) % 64]}, 32'd7);
    checkOutput("seq_k3", {28'd0, keyLog[(baseV + 3) % 64]}, 32'd9);
    checkOutput("seq_enter", enterCount - baseE, 32'd1);
    checkOutput("seq_enter_key", {28'd0, enterKeyIn}, 32'd9);
    checkOutput("seq_keyin", {28'd0, key_in}, 32'd9);

    $display("[TB] bounce 5");
    baseV = validCount;
    for (int i = 0; i < 3; i++) begin
      pressed[5] = 1'b1;
      repeat (4) @(posedge clk);
      pressed[5] = 1'b0;
      repeat (4) @(posedge clk);
    end
    repeat (40) @(posedge clk);
    #1;
    checkOutput("bounce_count", validCount - baseV, 32'd0);
    applyStimulus(5, 80, 80);
    checkOutput("clean5_count", validCount - baseV, 32'd1);
    checkOutput("clean5_keyin", {28'd0, key_in}, 32'd5);

    $display("[TB] multi-key");
    baseV = validCount;
    pressed[0] = 1'b1;
    applyStimulus(4, 80, 0);
    pressed[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("same_col_count", validCount - baseV, 32'd0);
    waitCol(4'b1110);
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("two_col_count", validCount - baseV, 32'd1);
    checkOutput("two_col_key", {28'd0, key_in}, 32'd1);
    pressed[1] = 1'b0;
    repeat (60) @(posedge clk);
    pressed[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("second_rel_count", validCount - baseV, 32'd1);

    $display("[TB] reset mid-debounce");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    baseV = validCount;
    baseE = enterCount;
    waitCol(4'b1101);
    pressed[9] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    pressed[9] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("rstdeb_count", validCount - baseV, 32'd0);
    checkOutput("rstdeb_keyin", {28'd0, key_in}, 32'd0);
    applyStimulus(12, 80, 80);
    applyStimulus(3, 80, 80);
    checkOutput("star_a_valid", validCount - baseV, 32'd0);
    checkOutput("star_a_enter", enterCount - baseE, 32'd0);

    $display("[TB] key held through reset");
    baseV = validCount;
    pressed[2] = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(2, 80, 40);
    checkOutput("held_rst_count", validCount - baseV, 32'd1);
    checkOutput("held_rst_keyin", {28'd0, key_in}, 32'd3);
    checkOutput("never_both", bothCount, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
